// File: rtl/vx_prefetch_perf_tracker_if.sv
// Event and counter bundle between the cache bank pipeline and the prefetch perf tracker.
// master: the pipeline side that raises the strobes; slave: the tracker that returns the counters.
interface vx_prefetch_perf_tracker_if #(
  parameter int LINE_BITS = 8,
  parameter int CTR_BITS  = 44
);
  logic                 pf_req_valid;
  logic [LINE_BITS-1:0] pf_req_line;
  logic                 fill_valid;
  logic                 fill_is_pf;
  logic [LINE_BITS-1:0] fill_line;
  logic                 hit_valid;
  logic [LINE_BITS-1:0] hit_line;
  logic                 dmiss_valid;
  logic [LINE_BITS-1:0] dmiss_line;
  logic                 evict_valid;
  logic [LINE_BITS-1:0] evict_line;
  logic [CTR_BITS-1:0]  prefetch_requests;
  logic [CTR_BITS-1:0]  prefetched_blocks;
  logic [CTR_BITS-1:0]  unused_prefetched_blocks;
  logic [CTR_BITS-1:0]  late_prefetches;

  modport master (
    output pf_req_valid, pf_req_line, fill_valid, fill_is_pf, fill_line,
           hit_valid, hit_line, dmiss_valid, dmiss_line, evict_valid, evict_line,
    input  prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches
  );

  modport slave (
    input  pf_req_valid, pf_req_line, fill_valid, fill_is_pf, fill_line,
           hit_valid, hit_line, dmiss_valid, dmiss_line, evict_valid, evict_line,
    output prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches
  );
endinterface

// File: rtl/vx_prefetch_perf_tracker.sv
// Per-line prefetch tracker producing the four prefetch perf counters.
// Optional: define VX_PF_PERF_SATURATE_EN to make counters saturate instead of wrapping.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_prefetch_perf_tracker #(
  parameter int LINES     = 256,
  parameter int LINE_BITS = $clog2(LINES),
  parameter int CTR_BITS  = `PERF_CTR_BITS
) (
  input logic                   clk,
  input logic                   reset,
  vx_prefetch_perf_tracker_if.slave bus
);

  typedef logic [CTR_BITS-1:0] ctr_t;
  typedef logic [LINES-1:0]    line_vec_t;

  function automatic ctr_t bump(input ctr_t c, input logic en);
`ifdef VX_PF_PERF_SATURATE_EN
    return (en && !(&c)) ? c + ctr_t'(1) : c;
`else
    return en ? c + ctr_t'(1) : c;
`endif
  endfunction

  line_vec_t pending_q, pending_d;
  line_vec_t unused_q,  unused_d;
  line_vec_t late_q,    late_d;
  ctr_t      req_q,     req_d;
  ctr_t      blk_q,     blk_d;
  ctr_t      unu_q,     unu_d;
  ctr_t      lat_q,     lat_d;

  logic inc_req, inc_blk, inc_unu, inc_lat;

  // NOTE: the events are applied one after another in priority order with blocking
  // assignments to the *_d copies, so a later event on the same line sees the earlier
  // event's effect within the same cycle; every *_d gets its default first (no latches).
  always_comb begin
    pending_d = pending_q;
    unused_d  = unused_q;
    late_d    = late_q;
    inc_req   = 1'b0;
    inc_blk   = 1'b0;
    inc_unu   = 1'b0;
    inc_lat   = 1'b0;

    if (bus.hit_valid) unused_d[bus.hit_line] = 1'b0;

    // Evict acts on the old occupant, after a same-cycle hit has marked it referenced.
    if (bus.evict_valid && unused_d[bus.evict_line]) begin
      inc_unu                    = 1'b1;
      unused_d[bus.evict_line]   = 1'b0;
    end

    if (bus.fill_valid) begin
      if (bus.fill_is_pf) begin
        inc_blk                  = 1'b1;
        unused_d[bus.fill_line]  = ~late_d[bus.fill_line];
        pending_d[bus.fill_line] = 1'b0;
        late_d[bus.fill_line]    = 1'b0;
      end else begin
        unused_d[bus.fill_line]  = 1'b0;
      end
    end

    if (bus.dmiss_valid && pending_d[bus.dmiss_line] && !late_d[bus.dmiss_line]) begin
      inc_lat                  = 1'b1;
      late_d[bus.dmiss_line]   = 1'b1;
    end

    if (bus.pf_req_valid) begin
      inc_req                    = 1'b1;
      pending_d[bus.pf_req_line] = 1'b1;
      late_d[bus.pf_req_line]    = 1'b0;
    end

    req_d = bump(req_q, inc_req);
    blk_d = bump(blk_q, inc_blk);
    unu_d = bump(unu_q, inc_unu);
    lat_d = bump(lat_q, inc_lat);
  end

  // NOTE: the per-line vectors are reset along with the counters so that a reset
  // really discards in-flight prefetches; they are flops, not a RAM, so this is cheap to do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      unused_q  <= '0;
      late_q    <= '0;
      req_q     <= '0;
      blk_q     <= '0;
      unu_q     <= '0;
      lat_q     <= '0;
    end else begin
      pending_q <= pending_d;
      unused_q  <= unused_d;
      late_q    <= late_d;
      req_q     <= req_d;
      blk_q     <= blk_d;
      unu_q     <= unu_d;
      lat_q     <= lat_d;
    end
  end

  assign bus.prefetch_requests        = req_q;
  assign bus.prefetched_blocks        = blk_q;
  assign bus.unused_prefetched_blocks = unu_q;
  assign bus.late_prefetches          = lat_q;

endmodule

// File: tb/tb_vx_prefetch_perf_tracker.sv
// Self-checking bench for vx_prefetch_perf_tracker: directed scenarios plus random traffic
// compared against a per-line lifecycle model of prefetched lines.
module tb_vx_prefetch_perf_tracker;
  localparam int LINES = 16;
  localparam int LB    = 4;
  localparam int CB    = 5;
  typedef logic [CB-1:0] ctr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vx_prefetch_perf_tracker_if #(.LINE_BITS(LB), .CTR_BITS(CB)) bus ();

  vx_prefetch_perf_tracker #(.LINES(LINES), .LINE_BITS(LB), .CTR_BITS(CB)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    bit pf;   int pfl;
    bit fill; bit fpf; int fl;
    bit hit;  int hl;
    bit dm;   int dl;
    bit ev;   int el;
  } ev_t;

  // Lifecycle of a line from the prefetcher's point of view.
  typedef struct {
    bit in_flight;   // requested, fill not yet seen
    bit caught;      // a demand miss found it in flight
    bit unref;       // resident prefetched line nobody has touched
  } line_t;

  line_t m_line[LINES];
  ctr_t  m_req, m_blk, m_unu, m_lat;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic ctr_t nxt(input ctr_t c);
`ifdef VX_PF_PERF_SATURATE_EN
    return (c == {CB{1'b1}}) ? c : ctr_t'(c + 1);
`else
    return ctr_t'((int'(c) + 1) % (1 << CB));
`endif
  endfunction

  task automatic model_reset();
    foreach (m_line[i]) m_line[i] = '{default: 0};
    m_req = '0; m_blk = '0; m_unu = '0; m_lat = '0;
  endtask

  task automatic model_step(input ev_t e);
    if (e.hit) m_line[e.hl].unref = 0;
    if (e.ev && m_line[e.el].unref) begin
      m_unu = nxt(m_unu);
      m_line[e.el].unref = 0;
    end
    if (e.fill) begin
      if (e.fpf) begin
        m_blk = nxt(m_blk);
        m_line[e.fl].unref     = !m_line[e.fl].caught;
        m_line[e.fl].in_flight = 0;
        m_line[e.fl].caught    = 0;
      end else begin
        m_line[e.fl].unref = 0;
      end
    end
    if (e.dm && m_line[e.dl].in_flight && !m_line[e.dl].caught) begin
      m_lat = nxt(m_lat);
      m_line[e.dl].caught = 1;
    end
    if (e.pf) begin
      m_req = nxt(m_req);
      m_line[e.pfl].in_flight = 1;
      m_line[e.pfl].caught    = 0;
    end
  endtask

  task automatic check(input string tag, input ctr_t obs, input ctr_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},    bus.prefetch_requests,        m_req);
    check({tag, ".blk"},    bus.prefetched_blocks,        m_blk);
    check({tag, ".unused"}, bus.unused_prefetched_blocks, m_unu);
    check({tag, ".late"},   bus.late_prefetches,          m_lat);
  endtask

  task automatic apply(input ev_t e, input string tag);
    bus.pf_req_valid = e.pf;   bus.pf_req_line = LB'(e.pfl);
    bus.fill_valid   = e.fill; bus.fill_is_pf  = e.fpf; bus.fill_line = LB'(e.fl);
    bus.hit_valid    = e.hit;  bus.hit_line    = LB'(e.hl);
    bus.dmiss_valid  = e.dm;   bus.dmiss_line  = LB'(e.dl);
    bus.evict_valid  = e.ev;   bus.evict_line  = LB'(e.el);
    // Nothing may move before the edge that samples the strobes.
    #1;
    check_all({tag, ".pre"});
    @(posedge clk);
    model_step(e);
    #1;
    check_all(tag);
  endtask

  task automatic do_pf(input int l, input string tag);
    ev_t e = '{default: 0}; e.pf = 1; e.pfl = l; apply(e, tag);
  endtask
  task automatic do_pfill(input int l, input string tag);
    ev_t e = '{default: 0}; e.fill = 1; e.fpf = 1; e.fl = l; apply(e, tag);
  endtask
  task automatic do_hit(input int l, input string tag);
    ev_t e = '{default: 0}; e.hit = 1; e.hl = l; apply(e, tag);
  endtask
  task automatic do_evict(input int l, input string tag);
    ev_t e = '{default: 0}; e.ev = 1; e.el = l; apply(e, tag);
  endtask
  task automatic do_dmiss(input int l, input string tag);
    ev_t e = '{default: 0}; e.dm = 1; e.dl = l; apply(e, tag);
  endtask
  task automatic do_idle(input string tag);
    ev_t e = '{default: 0}; apply(e, tag);
  endtask

  initial begin
    ev_t e;
    ctr_t wrap_exp;
    model_reset();
    e = '{default: 0};
    bus.pf_req_valid = 0; bus.pf_req_line = '0;
    bus.fill_valid = 0; bus.fill_is_pf = 0; bus.fill_line = '0;
    bus.hit_valid = 0; bus.hit_line = '0;
    bus.dmiss_valid = 0; bus.dmiss_line = '0;
    bus.evict_valid = 0; bus.evict_line = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic flow: request, fill, hit, evict.
    do_pf(5, "basic_req");
    do_pfill(5, "basic_fill");
    do_hit(5, "basic_hit");
    do_evict(5, "basic_evict");

    // Unused prefetch counted once.
    do_pf(9, "unused_req");
    do_pfill(9, "unused_fill");
    do_evict(9, "unused_evict");
    do_evict(9, "unused_evict2");

    // Late prefetch counted once, and its fill is not left unused.
    do_pf(3, "late_req");
    repeat (3) do_dmiss(3, "late_miss");
    do_pfill(3, "late_fill");
    do_evict(3, "late_evict");
    do_dmiss(11, "miss_nonpending");

    // Same-cycle hit+evict, then evict+pf fill on line 7.
    do_pf(7, "sc_req");
    do_pfill(7, "sc_fill");
    e = '{default: 0}; e.hit = 1; e.hl = 7; e.ev = 1; e.el = 7;
    apply(e, "sc_hit_evict");
    do_pf(7, "sc_req2");
    do_pfill(7, "sc_fill2");
    e = '{default: 0}; e.ev = 1; e.el = 7; e.fill = 1; e.fpf = 1; e.fl = 7;
    apply(e, "sc_evict_fill");
    do_evict(7, "sc_evict_new");

    // Same-cycle pf_req + pf fill: the new request stays pending and can be caught late.
    e = '{default: 0}; e.pf = 1; e.pfl = 2; e.fill = 1; e.fpf = 1; e.fl = 2;
    apply(e, "sc_req_fill");
    do_dmiss(2, "sc_req_fill_miss");

    // Random traffic on a small line space to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      e.pf   = ($urandom_range(0, 2) == 0); e.pfl = $urandom_range(0, LINES - 1);
      e.fill = ($urandom_range(0, 2) == 0); e.fpf = $urandom_range(0, 1) == 1;
      e.fl   = $urandom_range(0, LINES - 1);
      e.hit  = ($urandom_range(0, 2) == 0); e.hl  = $urandom_range(0, LINES - 1);
      e.dm   = ($urandom_range(0, 2) == 0); e.dl  = $urandom_range(0, LINES - 1);
      e.ev   = ($urandom_range(0, 2) == 0); e.el  = $urandom_range(0, LINES - 1);
      apply(e, "rand");
    end

    // Mid-run reset with an unused line 9 and nonzero counters.
    do_idle("pre_rst_idle");
    do_pf(9, "pre_rst_req");
    do_pfill(9, "pre_rst_fill");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.req",    bus.prefetch_requests,        ctr_t'(0));
    check("midrst.blk",    bus.prefetched_blocks,        ctr_t'(0));
    check("midrst.unused", bus.unused_prefetched_blocks, ctr_t'(0));
    check("midrst.late",   bus.late_prefetches,          ctr_t'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_evict(9, "post_rst_evict");

    // Wrap / saturate on prefetch_requests.
    for (int i = 0; i < (1 << CB) - 1; i++) do_pf(0, "wrap_fill");
    check("wrap.allones", bus.prefetch_requests, {CB{1'b1}});
    do_pf(0, "wrap_last");
`ifdef VX_PF_PERF_SATURATE_EN
    wrap_exp = {CB{1'b1}};
`else
    wrap_exp = '0;
`endif
    check("wrap.result", bus.prefetch_requests, wrap_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vx_prefetch_perf_tracker.md
Name: VX_prefetch_perf_tracker

Overview:
Per-cache event tracker that turns raw prefetch, fill, hit, miss and evict strobes from the cache bank pipeline into the four prefetch performance counters. Outputs drive the prefetch_requests, prefetched_blocks, unused_prefetched_blocks and late_prefetches fields of the cache perf interface master. Sits directly upstream of that interface. Keeps per-line state (pending / unused / late) so it can detect late and never-referenced prefetches.

Parameters:
LINES, 256, number of tracked cache line slots (sets x ways); power of two, >= 2
LINE_BITS, $clog2(LINES), line slot index width (derived)
CTR_BITS, `PERF_CTR_BITS, counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
pf_req_valid  input  1  prefetch request issued to memory this cycle
pf_req_line  input  LINE_BITS  destination line slot of the prefetch
fill_valid  input  1  line fill written into the data store
fill_is_pf  input  1  fill originated from a prefetch
fill_line  input  LINE_BITS  filled line slot
hit_valid  input  1  demand access hit
hit_line  input  LINE_BITS  line slot hit
dmiss_valid  input  1  demand miss merged or allocated in the MSHR
dmiss_line  input  LINE_BITS  line slot of the demand miss
evict_valid  input  1  line evicted or invalidated
evict_line  input  LINE_BITS  evicted line slot
prefetch_requests  output  CTR_BITS  prefetches issued
prefetched_blocks  output  CTR_BITS  prefetch fills installed
unused_prefetched_blocks  output  CTR_BITS  prefetched lines evicted without a demand reference
late_prefetches  output  CTR_BITS  prefetches that a demand miss caught while still in flight

Behaviour:
- Reset (asynchronous, active-low): all four counters = 0; per-line bit vectors pending, unused and late all = 0. Reset mid-operation discards all tracked state; in-flight prefetches are not counted afterwards.
- Counters are registered. An event in cycle N is visible on the outputs in cycle N+1. Each counter increments by at most 1 per cycle.
- pf_req_valid: prefetch_requests += 1; pending[pf_req_line] <= 1; late[pf_req_line] <= 0. A request to an already-pending line still counts.
- dmiss_valid with pending[dmiss_line]=1 and late[dmiss_line]=0: late_prefetches += 1; late <= 1. Further misses to the same pending line do not count. A miss to a non-pending line has no effect.
- fill_valid with fill_is_pf=1: prefetched_blocks += 1; pending <= 0; unused <= ~late (a late prefetch is already demand-referenced); late <= 0.
- fill_valid with fill_is_pf=0: unused[fill_line] <= 0; pending and late are unchanged.
- hit_valid: unused[hit_line] <= 0.
- evict_valid with unused[evict_line]=1: unused_prefetched_blocks += 1; unused <= 0.
- Same-line, same-cycle priority, in order: hit, then evict (old occupant), then fill (new occupant), then dmiss, then pf_req.
  - hit+evict: hit clears unused first, so no unused count.
  - evict+pf fill: the old line is counted if unused; the new line gets unused=1.
  - pf_req+fill: pending is left at 1 (the newer request wins).
- Events on different lines in the same cycle are independent, and all applicable counters update.
- Wrap-around: counters wrap modulo 2^CTR_BITS (all-ones + 1 = 0) unless the optional feature is enabled.
- Per-line state lives in flops (LINES bits x 3). Read-modify-write is single-cycle; there is no back-pressure and no ready signals. Inputs are assumed valid every cycle they are asserted.

Optional Feature:
VX_PF_PERF_SATURATE_EN
- Defined: every counter saturates at all-ones and holds there; further increments are dropped.
- Undefined: counters wrap to 0 as described above.
- No port or latency change either way.

Test Plan:
- Reset: drive reset low mid-run with nonzero counters -> all four outputs read 0 in the same cycle; after release, an evict on a previously unused line does not increment unused_prefetched_blocks.
- Basic flow: pf_req line 5, then pf fill line 5, then hit line 5, then evict line 5 -> requests=1, blocks=1, unused=0, late=0; each update appears 1 cycle after its strobe.
- Unused: pf_req line 9, pf fill line 9, evict line 9 with no hit -> unused=1; a second evict on line 9 -> unused stays 1.
- Late: pf_req line 3, then three dmiss line 3 before the fill -> late=1; the fill sets no unused bit; a later evict of line 3 -> unused=0.
- Same-cycle: hit+evict line 7 (unused=1) -> unused count unchanged; evict+pf fill line 7 with unused=1 -> unused +1, blocks +1, and unused[7]=1 afterwards.
- Wrap/saturate: preload prefetch_requests to 2^CTR_BITS-1 via repeated pf_req (or force), then one more pf_req -> 0 without the macro, all-ones with VX_PF_PERF_SATURATE_EN.
